// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer: ALU write-back FIFO retiring to the scalar/vector RF ports.
// Optional macro WB_BYPASS_EN: zero-latency scalar bypass into an idle buffer.
module alu_wb_buffer #(
  parameter int DEPTH = 4,
  parameter int VW    = 64,
  parameter int RA_W  = 4,
  localparam int VBEATS = 256 / VW,
  localparam int BW     = (VBEATS > 1) ? $clog2(VBEATS) : 1,
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [255:0]    in_result,
  input  logic            in_rf_sel,
  input  logic [RA_W-1:0] in_rd,
  input  logic [3:0]      in_flags,
  output logic            sc_we,
  output logic [RA_W-1:0] sc_waddr,
  output logic [15:0]     sc_wdata,
  output logic            vr_we,
  output logic [RA_W-1:0] vr_waddr,
  output logic [BW-1:0]   vr_beat,
  output logic [VW-1:0]   vr_wdata,
  input  logic            vr_wready,
  output logic [3:0]      flags,
  output logic            busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_VEC  = 1'b1
  } state_t;

  localparam logic [BW-1:0] LAST_BEAT = BW'(VBEATS - 1);
  localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(DEPTH);

  // entry storage: payload is not reset, only pointers/count are
  logic [255:0]    res_q   [DEPTH];
  logic            sel_q   [DEPTH];
  logic [RA_W-1:0] rd_q    [DEPTH];
  logic [3:0]      fl_q    [DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [3:0]      flags_q, flags_d;

  logic            push;
  logic            pop;
  logic            byp;
  logic            empty;
  logic            full;

  logic [255:0]    head_res;
  logic            head_sel;
  logic [RA_W-1:0] head_rd;
  logic [3:0]      head_fl;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign in_ready = !full;

  assign head_res = res_q[rd_ptr_q];
  assign head_sel = sel_q[rd_ptr_q];
  assign head_rd  = rd_q[rd_ptr_q];
  assign head_fl  = fl_q[rd_ptr_q];

  assign flags = flags_q;
  assign busy  = !empty || (state_q != S_IDLE);

  // bypass only when nothing older could still be waiting to retire
`ifdef WB_BYPASS_EN
  assign byp = empty && (state_q == S_IDLE) && in_valid && !in_rf_sel;
`else
  assign byp = 1'b0;
`endif

  assign push = in_valid && !full && !byp;

  // write a new entry into the tail slot
  always_ff @(posedge clk) begin
    if (push) begin
      res_q[wr_ptr_q] <= in_result;
      sel_q[wr_ptr_q] <= in_rf_sel;
      rd_q[wr_ptr_q]  <= in_rd;
      fl_q[wr_ptr_q]  <= in_flags;
    end
  end

  // pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // retire FSM: next state, pop decision and write-port drive
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    flags_d  = flags_q;
    pop      = 1'b0;
    sc_we    = 1'b0;
    sc_waddr = '0;
    sc_wdata = '0;
    vr_we    = 1'b0;
    vr_waddr = '0;
    vr_beat  = '0;
    vr_wdata = '0;
    unique case (state_q)
      S_IDLE: begin
        if (byp) begin
          sc_we    = 1'b1;
          sc_waddr = in_rd;
          sc_wdata = in_result[15:0];
          flags_d  = in_flags;
        end else if (!empty) begin
          if (head_sel) begin
            state_d = S_VEC;
            beat_d  = '0;
          end else begin
            sc_we    = 1'b1;
            sc_waddr = head_rd;
            sc_wdata = head_res[15:0];
            flags_d  = head_fl;
            pop      = 1'b1;
          end
        end
      end
      S_VEC: begin
        vr_we    = 1'b1;
        vr_waddr = head_rd;
        vr_beat  = beat_q;
        vr_wdata = head_res[int'(beat_q) * VW +: VW];
        if (vr_wready) begin
          if (beat_q == LAST_BEAT) begin
            pop     = 1'b1;
            beat_d  = '0;
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // FSM, beat counter and architectural flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      flags_q <= flags_d;
    end
  end

endmodule
